// File: rtl/store_unit_pkg.sv
// Shared instruction-id and state-encoding defines plus store_unit types.
// Optional feature macro used by this block: STORE_MISALIGN_TRAP_EN.
`ifndef STORE_UNIT_DEFINES
`define STORE_UNIT_DEFINES
`define INST_ID_LEN 6
`define NONE_ID     6'd0
`define SB_ID       6'd20
`define SH_ID       6'd21
`define SW_ID       6'd22
`define On          1'b1
`define Off         1'b0
`define ST_IDLE     2'd0
`define ST_REQ      2'd1
`define ST_RESP     2'd2
`endif

package store_unit_pkg;

  typedef logic [`INST_ID_LEN-1:0] inst_id_t;

  typedef enum logic [1:0] {
    StIdle = `ST_IDLE,
    StReq  = `ST_REQ,
    StResp = `ST_RESP
  } state_e;

  // True only for the ids this unit executes.
  function automatic logic is_store(inst_id_t id);
    return (id == `SB_ID) || (id == `SH_ID) || (id == `SW_ID);
  endfunction

endpackage

// File: rtl/store_unit_if.sv
// Data-memory write port: req/gnt request phase, rvalid/err completion phase.
interface store_unit_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              req;
  logic              gnt;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              rvalid;
  logic              err;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, err);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, err);
endinterface

// File: rtl/store_lane_align.sv
// Byte-lane formation for SB/SH/SW: byte enables, replicated data, misalign flag.
module store_lane_align
  import store_unit_pkg::*;
(
  input  inst_id_t    id_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  // Decode the access size into lanes; unknown ids produce no lanes.
  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = 32'h0;
    misalign_o = 1'b0;
    case (id_i)
      `SB_ID: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      `SH_ID: begin
        be_o       = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = offset_i[0];
      end
      `SW_ID: begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        misalign_o = |offset_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store side of the MEM stage: issues one aligned write on the dmem bus and
// stalls the pipeline until it completes, errors or times out.
// Optional: STORE_MISALIGN_TRAP_EN traps misaligned SH/SW instead of issuing.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid_i,
  output logic              st_ready_o,
  input  inst_id_t          instr_id_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  store_unit_if.master      dmem,
  output logic              stall_o,
  output logic              done_o,
  output logic              exc_o,
  output logic [ADDR_W-1:0] exc_addr_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] waddr_q, raw_q, exc_addr_q;
  logic [3:0]        be_q, lane_be;
  logic [31:0]       wdata_q, lane_wdata;
  logic              mis_q, lane_mis, trap, accept, timeout, resp;

  store_lane_align u_lane (
    .id_i       (instr_id_i),
    .offset_i   (addr_i[1:0]),
    .wdata_i    (wdata_i),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .misalign_o (lane_mis)
  );

`ifdef STORE_MISALIGN_TRAP_EN
  assign trap = lane_mis;
`else
  // Misalignment is tolerated: the word address and lane decode already
  // ignore the bits that natural alignment would clear.
  assign trap = lane_mis & `Off;
`endif

  assign accept  = st_valid_i && st_ready_o && is_store(instr_id_i);
  assign timeout = (cnt_q == CntW'(TIMEOUT));

  // Everything is gated by rst so an abandoned transaction cannot pulse.
  assign st_ready_o = !rst && (state_q == StIdle);
  assign stall_o    = !rst && ((state_q != StIdle) || (st_valid_i && is_store(instr_id_i)));
  assign dmem.req   = !rst && (state_q == StReq);
  assign dmem.we    = dmem.req;
  assign dmem.addr  = waddr_q;
  assign dmem.be    = be_q;
  assign dmem.wdata = wdata_q;

  assign resp       = !rst && (state_q == StResp) && dmem.rvalid;
  assign done_o     = resp && !dmem.err;
  assign exc_o      = (resp && dmem.err)
                    || (!rst && (state_q == StResp) && !dmem.rvalid && timeout)
                    || (!rst && mis_q);
  // Faulting address is visible in the same cycle as the pulse, then held.
  assign exc_addr_o = exc_o ? raw_q : exc_addr_q;

  // State, timeout counter and captured transaction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      waddr_q    <= '0;
      raw_q      <= '0;
      exc_addr_q <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= 32'h0;
      mis_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= accept && trap;
      if (accept) begin
        waddr_q <= {addr_i[ADDR_W-1:2], 2'b00};
        raw_q   <= addr_i;
        be_q    <= lane_be;
        wdata_q <= lane_wdata;
      end
      if (exc_o) exc_addr_q <= raw_q;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept && !trap) state_d = StReq;
      end
      StReq: begin
        if (dmem.gnt) begin
          state_d = StResp;
          cnt_d   = '0;
        end
      end
      StResp: begin
        if (dmem.rvalid || timeout) state_d = StIdle;
        else                        cnt_d   = cnt_q + CntW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_store_unit.sv
// Randomized self-checking bench for store_unit against a transaction-level model.
module tb_store_unit;
  import store_unit_pkg::*;

  localparam int unsigned AW = 32;
  localparam int          TO = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid, st_ready, stall, done, exc;
  inst_id_t      instr_id;
  logic [AW-1:0] addr, exc_addr;
  logic [31:0]   wdata;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [AW-1:0] last_exc_addr = '0;

  always #5 clk = ~clk;

  store_unit_if #(.ADDR_W(AW)) dmem ();

  store_unit #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .st_valid_i (st_valid),
    .st_ready_o (st_ready),
    .instr_id_i (instr_id),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .dmem       (dmem),
    .stall_o    (stall),
    .done_o     (done),
    .exc_o      (exc),
    .exc_addr_o (exc_addr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Reference model: lane rules from plain arithmetic.
  function automatic logic [3:0] exp_be(inst_id_t id, logic [1:0] a);
    int sh = int'(a);
    if (id == `SB_ID) return 4'(1 << sh);
    if (id == `SH_ID) return (sh >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] exp_data(inst_id_t id, logic [31:0] w);
    logic [31:0] b = {24'h0, w[7:0]};
    logic [31:0] h = {16'h0, w[15:0]};
    if (id == `SB_ID) return b * 32'h0101_0101;
    if (id == `SH_ID) return h * 32'h0001_0001;
    return w;
  endfunction

  function automatic bit exp_trap(inst_id_t id, logic [1:0] a);
    bit mis = ((id == `SH_ID) && (a % 2 != 0)) || ((id == `SW_ID) && (a != 0));
`ifdef STORE_MISALIGN_TRAP_EN
    return mis;
`else
    return mis & 1'b0;
`endif
  endfunction

  // One complete store; rsp_dly < 0 means rvalid never comes. Entered and
  // left at posedge+1 with the unit idle.
  task automatic run_store(input inst_id_t id, input logic [AW-1:0] a, input logic [31:0] d,
                           input int gnt_dly, input int rsp_dly, input bit err);
    bit   trap = exp_trap(id, a[1:0]);
    bit   fin  = 1'b0;
    st_valid = 1'b1; instr_id = id; addr = a; wdata = d;
    @(negedge clk);
    check("acc_ready", st_ready, 1);
    check("acc_stall", stall, 1);
    check("acc_req", dmem.req, 0);
    next();
    st_valid = 1'b0; instr_id = `NONE_ID;
    if (trap) begin
      @(negedge clk);
      check("mis_exc", exc, 1);
      check("mis_exc_addr", exc_addr, a);
      check("mis_req", dmem.req, 0);
      check("mis_done", done, 0);
      last_exc_addr = a;
      next();
    end else begin
      for (int k = 0; k <= gnt_dly; k++) begin
        dmem.gnt = (k == gnt_dly);
        @(negedge clk);
        check("req", dmem.req, 1);
        check("we", dmem.we, 1);
        check("addr", dmem.addr, {a[AW-1:2], 2'b00});
        check("be", dmem.be, exp_be(id, a[1:0]));
        check("wdata", dmem.wdata, exp_data(id, d));
        check("req_stall", stall, 1);
        next();
      end
      dmem.gnt = 1'b0;
      for (int k = 0; k <= TO && !fin; k++) begin
        dmem.rvalid = (k == rsp_dly);
        dmem.err    = err;
        @(negedge clk);
        if (k == rsp_dly) begin
          check("resp_done", done, !err);
          check("resp_exc", exc, err);
          if (err) begin
            check("err_exc_addr", exc_addr, a);
            last_exc_addr = a;
          end
          fin = 1'b1;
        end else if (k == TO) begin
          check("timeout_exc", exc, 1);
          check("timeout_done", done, 0);
          check("timeout_exc_addr", exc_addr, a);
          last_exc_addr = a;
          fin = 1'b1;
        end else begin
          check("wait_pulses", {done, exc}, 2'b00);
          check("wait_stall", stall, 1);
          check("wait_req", dmem.req, 0);
        end
        next();
      end
      dmem.rvalid = 1'b0; dmem.err = 1'b0;
    end
    @(negedge clk);
    check("post_ready", st_ready, 1);
    check("post_stall", stall, 0);
    check("post_pulses", {done, exc}, 2'b00);
    check("post_exc_addr", exc_addr, last_exc_addr);
    next();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    inst_id_t ids [3];
    ids[0] = `SB_ID; ids[1] = `SH_ID; ids[2] = `SW_ID;
    rst = 1'b1; st_valid = 1'b0; instr_id = `NONE_ID; addr = '0; wdata = '0;
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.err = 1'b0;
    repeat (3) next();
    @(negedge clk);
    check("rst_ready", st_ready, 0);
    check("rst_outs", {dmem.req, stall, done, exc}, 4'b0000);
    check("rst_exc_addr", exc_addr, 0);
    next();
    rst = 1'b0;
    @(negedge clk);
    check("rst_rel_ready", st_ready, 1);
    next();

    // Bus activity while idle is ignored.
    dmem.gnt = 1'b1; dmem.rvalid = 1'b1; dmem.err = 1'b1;
    @(negedge clk);
    check("idle_ign", {dmem.req, done, exc, stall}, 4'b0000);
    next();
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.err = 1'b0;
    @(negedge clk);
    check("idle_ign_ready", st_ready, 1);
    next();

    run_store(`SB_ID, 32'h1003, 32'h0000_00A5, 0, 0, 1'b0);
    run_store(`SH_ID, 32'h2002, 32'h1234_BEEF, 3, 1, 1'b0);
    run_store(`SW_ID, 32'h3000, 32'hCAFE_F00D, 0, 0, 1'b1);
    run_store(`SW_ID, 32'h4000, 32'h0BAD_0BAD, 1, -1, 1'b0);
    run_store(`SW_ID, 32'h4002, 32'h8765_4321, 0, 0, 1'b0);

    // Reset while waiting for the completion abandons the store.
    st_valid = 1'b1; instr_id = `SW_ID; addr = 32'h5000; wdata = 32'h1111_2222;
    next();
    st_valid = 1'b0; instr_id = `NONE_ID; dmem.gnt = 1'b1;
    @(negedge clk);
    check("rr_req", dmem.req, 1);
    next();
    dmem.gnt = 1'b0;
    @(negedge clk);
    check("rr_resp_stall", stall, 1);
    next();
    rst = 1'b1; dmem.rvalid = 1'b1;
    @(negedge clk);
    check("rr_no_pulse", {done, exc}, 2'b00);
    next();
    rst = 1'b0; dmem.rvalid = 1'b0;
    last_exc_addr = '0;
    @(negedge clk);
    check("rr_idle", st_ready, 1);
    check("rr_exc_addr", exc_addr, 0);
    check("rr_pulses", {done, exc}, 2'b00);
    next();
    st_valid = 1'b1; instr_id = `NONE_ID; addr = 32'h5001; wdata = 32'hA5;
    @(negedge clk);
    check("bogus_stall", stall, 0);
    check("bogus_req", dmem.req, 0);
    next();
    st_valid = 1'b0;
    @(negedge clk);
    check("bogus_req2", dmem.req, 0);
    check("bogus_ready", st_ready, 1);
    next();

    for (int i = 0; i < 40; i++) begin
      int rsp;
      rsp = ($urandom_range(15) == 0) ? -1 : int'($urandom_range(4));
      run_store(ids[$urandom_range(2)], $urandom, $urandom, int'($urandom_range(3)), rsp,
                ($urandom_range(7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Executes the store side of the memory stage. It accepts an already-identified store (SB/SH/SW instruction id), address and register data.
- Produces the byte-lane-aligned write transaction on the data-memory bus using a req/gnt request phase and an rvalid/err completion phase.
- Stalls the pipeline until the write completes.
- Sits between the MEM-stage control and the data-memory port, downstream of the store identifier.

Parameters:
- ADDR_W, 32, address width
- TIMEOUT, 255, maximum cycles in RESP before a bus-timeout error; counter width is clog2(TIMEOUT+1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- st_valid_i  in  1  store request valid
- st_ready_o  out  1  unit can accept a store (high only in IDLE)
- instr_id_i  in  `INST_ID_LEN  `SB_ID / `SH_ID / `SW_ID; anything else is ignored
- addr_i  in  ADDR_W  effective byte address
- wdata_i  in  32  rs2 value
- dmem_req_o  out  1  bus request
- dmem_gnt_i  in  1  bus grant
- dmem_we_o  out  1  write enable, equal to dmem_req_o
- dmem_addr_o  out  ADDR_W  word-aligned address (low 2 bits zero)
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-shifted data
- dmem_rvalid_i  in  1  write completion
- dmem_err_i  in  1  bus error, sampled with rvalid
- stall_o  out  1  pipeline stall
- done_o  out  1  one-cycle pulse when a store retires without error
- exc_o  out  1  one-cycle store exception pulse
- exc_addr_o  out  ADDR_W  faulting address, held until the next exception

Behaviour:
- Reset: state IDLE, all outputs 0 (including exc_addr_o), timeout counter 0. st_ready_o becomes 1 the first cycle after reset deasserts.
- FSM states: IDLE, REQ, RESP.
  - IDLE -> REQ when st_valid_i && st_ready_o && the id is one of SB/SH/SW. The unit registers be, shifted data, word address and raw address.
  - An invalid id with valid high: the store is dropped, no bus activity, no stall.
  - REQ: dmem_req_o=1 with stable addr/be/wdata until dmem_gnt_i. If gnt=1 in a REQ cycle, go to RESP next cycle.
  - RESP: wait for dmem_rvalid_i.
    - rvalid && !err: done_o pulses, go to IDLE.
    - rvalid && err: exc_o pulses, exc_addr_o = raw address, go to IDLE.
    - rvalid in the same cycle as the timeout expiry: rvalid takes priority.
  - Timeout counter clears on RESP entry and increments each RESP cycle. At TIMEOUT with no rvalid: exc_o pulses, go to IDLE.
- Lane formation (byte offset a = addr[1:0]):
  - SB: be = 4'b0001 << a, data = {4{wdata[7:0]}}.
  - SH: be = 4'b0011 << (a[1]*2), data = {2{wdata[15:0]}}.
  - SW: be = 4'b1111, data = wdata.
- stall_o = st_valid_i in IDLE for a valid store, and 1 in REQ and RESP. A new store enters no earlier than the cycle after returning to IDLE.
- rvalid/gnt seen in IDLE are ignored.
- rst asserted in REQ or RESP: IDLE next cycle, outstanding transaction abandoned, no done/exc pulse.
- Minimum latency with gnt and rvalid immediate: accept at cycle 0, req at cycle 1, done at cycle 2.

Optional Feature:
- Macro: STORE_MISALIGN_TRAP_EN.
- Defined: SH with addr[0]=1, or SW with addr[1:0]!=0, raises exc_o the cycle after acceptance. exc_addr_o = addr_i, no bus request, FSM returns to IDLE.
- Undefined: the low address bits are forced to the natural alignment (SH clears bit 0, SW clears bits 1:0) and the store is issued normally with no exception.

Decomposition:
- Shared define header, alongside the existing instruction-id defines: `SB_ID/`SH_ID/`SW_ID, `INST_ID_LEN, `On/`Off, and new state encodings `ST_IDLE/`ST_REQ/`ST_RESP.
- One natural combinational sub-module, store_lane_align: id + addr[1:0] + wdata -> be, wdata, misalign flag.

Test Plan:
- SB, addr=0x1003, wdata=0xA5, gnt and rvalid immediate -> dmem_addr_o=0x1000, be=4'b1000, wdata=0xA5A5A5A5, done_o at cycle 2.
- SH, addr=0x2002, wdata=0x1234BEEF, gnt delayed 3 cycles -> req/addr/be=4'b1100/wdata stable 4 cycles, stall_o high throughout, single done_o.
- SW, addr=0x3000, rvalid with err=1 -> exc_o pulse, exc_addr_o=0x3000, no done_o.
- SW, rvalid never arrives, TIMEOUT=255 -> exc_o exactly 255 cycles after RESP entry, then st_ready_o=1.
- SW, addr=0x4002 -> with macro: exc_o, exc_addr_o=0x4002, dmem_req_o never high. Without macro: dmem_addr_o=0x4000, be=4'b1111, done_o.
- rst pulsed during RESP, then SB valid with a bogus (NONE) id -> next cycle IDLE, no pulses, bogus id causes no req and no stall.
